// File: rtl/nor_seq_pkg.sv
// rtl/nor_seq_pkg.sv - shared types, step plans and step counts for the NOR sequencer
package nor_seq_pkg;

  localparam int STEP_W = 3;

  typedef enum logic [2:0] {
    OP_NOR  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_AND  = 3'd3,
    OP_NAND = 3'd4,
    OP_XNOR = 3'd5,
    OP_XOR  = 3'd6,
    OP_BUFA = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // NOR input sources
  typedef enum logic [2:0] {
    SRC_A  = 3'd0,
    SRC_B  = 3'd1,
    SRC_R1 = 3'd2,
    SRC_R2 = 3'd3,
    SRC_R3 = 3'd4
  } src_e;

  // Destination of one NOR evaluation
  typedef enum logic [1:0] {
    DST_R1 = 2'd0,
    DST_R2 = 2'd1,
    DST_R3 = 2'd2,
    DST_Y  = 2'd3
  } dst_e;

  typedef struct packed {
    src_e x;
    src_e y;
    dst_e dst;
  } step_t;

  // Number of NOR evaluations each function needs
  function automatic logic [STEP_W-1:0] op_steps(input op_e op);
    case (op)
      OP_NOR:  return 3'd1;
      OP_OR:   return 3'd2;
      OP_NOTA: return 3'd1;
      OP_AND:  return 3'd3;
      OP_NAND: return 3'd4;
      OP_XNOR: return 3'd4;
      OP_XOR:  return 3'd5;
      OP_BUFA: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  function automatic step_t mk(input src_e x, input src_e y, input dst_e d);
    step_t s;
    s.x   = x;
    s.y   = y;
    s.dst = d;
    return s;
  endfunction

  // Operand selection and write target for step 'step' of function 'op'.
  // Every sequence writes a scratch register before it reads it, so stale
  // scratch contents from a previous operation never leak into a result.
  function automatic step_t step_plan(input op_e op, input logic [STEP_W-1:0] step);
    step_t s;
    s = mk(SRC_A, SRC_A, DST_Y);
    case (op)
      OP_NOR:  s = mk(SRC_A, SRC_B, DST_Y);
      OP_OR: begin
        if (step == 3'd0) s = mk(SRC_A, SRC_B, DST_R1);
        else              s = mk(SRC_R1, SRC_R1, DST_Y);
      end
      OP_NOTA: s = mk(SRC_A, SRC_A, DST_Y);
      OP_AND, OP_NAND: begin
        case (step)
          3'd0:    s = mk(SRC_A, SRC_A, DST_R1);
          3'd1:    s = mk(SRC_B, SRC_B, DST_R2);
          3'd2:    s = mk(SRC_R1, SRC_R2, (op == OP_AND) ? DST_Y : DST_R3);
          default: s = mk(SRC_R3, SRC_R3, DST_Y);
        endcase
      end
      OP_XNOR, OP_XOR: begin
        case (step)
          3'd0:    s = mk(SRC_A, SRC_B, DST_R1);
          3'd1:    s = mk(SRC_A, SRC_R1, DST_R2);
          3'd2:    s = mk(SRC_B, SRC_R1, DST_R3);
          3'd3:    s = mk(SRC_R2, SRC_R3, (op == OP_XNOR) ? DST_Y : DST_R1);
          default: s = mk(SRC_R1, SRC_R1, DST_Y);
        endcase
      end
      OP_BUFA: begin
        if (step == 3'd0) s = mk(SRC_A, SRC_A, DST_R1);
        else              s = mk(SRC_R1, SRC_R1, DST_Y);
      end
      default: s = mk(SRC_A, SRC_A, DST_Y);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nor_vec.sv
// rtl/nor_vec.sv - WIDTH-bit bitwise NOR stage
module nor_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] z_o
);

  assign z_o = ~(x_i | y_i);

endmodule

// File: rtl/nor_seq_logic_unit.sv
// rtl/nor_seq_logic_unit.sv - eight logic functions built from one time-shared NOR stage
module nor_seq_logic_unit
  import nor_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q;
  op_e                 op_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [WIDTH-1:0]    r1_q, r2_q, r3_q;
  logic [WIDTH-1:0]    y_q;
  logic                done_q;

  step_t               plan;
  logic                last_step;
  logic [WIDTH-1:0]    nor_x, nor_y, nor_z;

  assign plan      = step_plan(op_q, step_q);
  assign last_step = (step_q == (op_steps(op_q) - STEP_W'(1)));

  // Route the current step's two operands into the shared NOR
  always_comb begin
    nor_x = a_q;
    nor_y = a_q;
    case (plan.x)
      SRC_A:   nor_x = a_q;
      SRC_B:   nor_x = b_q;
      SRC_R1:  nor_x = r1_q;
      SRC_R2:  nor_x = r2_q;
      SRC_R3:  nor_x = r3_q;
      default: nor_x = a_q;
    endcase
    case (plan.y)
      SRC_A:   nor_y = a_q;
      SRC_B:   nor_y = b_q;
      SRC_R1:  nor_y = r1_q;
      SRC_R2:  nor_y = r2_q;
      SRC_R3:  nor_y = r3_q;
      default: nor_y = a_q;
    endcase
  end

  nor_vec #(.WIDTH(WIDTH)) u_nor (
    .x_i (nor_x),
    .y_i (nor_y),
    .z_o (nor_z)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: accept in IDLE, leave RUN after the final step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    y    = y_q;
  end

  // Operand capture, step counter, scratch/result writes and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      op_q   <= OP_NOR;
      a_q    <= '0;
      b_q    <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      r3_q   <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op_e'(op);
            step_q <= '0;
          end
        end
        RUN: begin
          step_q <= step_q + STEP_W'(1);
          case (plan.dst)
            DST_R1:  r1_q <= nor_z;
            DST_R2:  r2_q <= nor_z;
            DST_R3:  r3_q <= nor_z;
            default: y_q  <= nor_z;
          endcase
          if (last_step) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
